// File: rtl/sdram_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-SDRAM-controller bridge.
package sdram_bridge_pkg;

  localparam int unsigned WB_AW  = 21;
  localparam int unsigned CTL_AW = 22;
  localparam int unsigned DW     = 16;
  localparam int unsigned TW     = 10;
  localparam int unsigned DLW    = 2;

  localparam logic [DW-1:0] TMO_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_REQ,
    ST_DLY,
    ST_ACK,
    ST_DRAIN
  } state_t;

  // Bus transaction latched on leaving IDLE.
  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [DW-1:0]    dat;
    logic             we;
  } wb_req_t;

endpackage

// File: rtl/sdram_rst_seq.sv
// Synchronises rst_n release and holds the controller reset low for RST_DELAY
// further cycles.
module sdram_rst_seq #(
  parameter int unsigned RST_DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  output logic ctl_rst_n
);

  localparam int unsigned CW = 4;

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b00;
      cnt       <= '0;
      ctl_rst_n <= 1'b0;
    end else begin
      sync <= {sync[0], 1'b1};
      if (sync[1] && !ctl_rst_n) begin
        if (cnt == CW'(RST_DELAY - 1)) ctl_rst_n <= 1'b1;
        else                           cnt       <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sdram_wb_bridge.sv
// Wishbone word bus to sdram_top request/ack bridge: reset sequencing, request
// generation, DQM latching, read capture and ack shaping with timeout guard.
module sdram_wb_bridge
  import sdram_bridge_pkg::*;
#(
  parameter int unsigned RST_DELAY = 3,
  parameter int unsigned ACK_DELAY = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stb,
  input  logic              wb_we,
  input  logic [1:0]        wb_sel,
  input  logic [WB_AW-1:0]  wb_adr,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack,
  output logic              wb_ready,
  output logic              tmo,
  output logic              ctl_rst_n,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  output logic [CTL_AW-1:0] sdram_addr,
  output logic [DW-1:0]     sdram_wdata,
  input  logic [DW-1:0]     sdram_rdata,
  output logic              sdram_udqm,
  output logic              sdram_ldqm,
  input  logic              sdram_init_done
);

  state_t          state, state_d;
  wb_req_t         req, req_d;
  logic [1:0]      dqm, dqm_d;
  logic            wr_req, wr_req_d, rd_req, rd_req_d;
  logic [DW-1:0]   dat_o, dat_d;
  logic            ack_r, ack_d, tmo_r, tmo_d, abort, abort_d;
  logic [TW-1:0]   tcnt, tcnt_d;
  logic [DLW-1:0]  dcnt, dcnt_d;
  logic            ready_r;
  logic            match_c, aborting_c, fin_c;

  sdram_rst_seq #(.RST_DELAY(RST_DELAY)) u_rst_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .ctl_rst_n (ctl_rst_n)
  );

  assign match_c    = req.we ? sdram_wr_ack : sdram_rd_ack;
  assign aborting_c = abort | ~wb_stb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_INIT;
      req     <= '0;
      dqm     <= 2'b00;
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      dat_o   <= '0;
      ack_r   <= 1'b0;
      tmo_r   <= 1'b0;
      abort   <= 1'b0;
      tcnt    <= '0;
      dcnt    <= '0;
      ready_r <= 1'b0;
    end else begin
      state   <= state_d;
      req     <= req_d;
      dqm     <= dqm_d;
      wr_req  <= wr_req_d;
      rd_req  <= rd_req_d;
      dat_o   <= dat_d;
      ack_r   <= ack_d;
      tmo_r   <= tmo_d;
      abort   <= abort_d;
      tcnt    <= tcnt_d;
      dcnt    <= dcnt_d;
      ready_r <= sdram_init_done & ctl_rst_n;
    end
  end

  always_comb begin
    state_d  = state;
    req_d    = req;
    dqm_d    = dqm;
    wr_req_d = wr_req;
    rd_req_d = rd_req;
    dat_d    = dat_o;
    ack_d    = ack_r;
    tmo_d    = tmo_r;
    abort_d  = abort;
    tcnt_d   = tcnt;
    dcnt_d   = dcnt;
    fin_c    = 1'b0;

    unique case (state)
      ST_INIT: if (ready_r) state_d = ST_IDLE;
      ST_IDLE: begin
        if (wb_stb) begin
          req_d   = '{adr: wb_adr, dat: wb_dat_i, we: wb_we};
          dqm_d   = wb_we ? ~wb_sel : 2'b00;
          abort_d = 1'b0;
          // A write with no byte enabled has nothing to send to the controller.
          if (wb_we && wb_sel == 2'b00) begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d  = ST_REQ;
            wr_req_d = wb_we;
            rd_req_d = ~wb_we;
            tcnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        abort_d = aborting_c;
        if (match_c) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          if (!req.we) dat_d = sdram_rdata;
          dcnt_d = '0;
          if (ACK_DELAY > 0) state_d = ST_DLY;
          else               fin_c   = 1'b1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          tmo_d    = 1'b1;
          if (!req.we) dat_d = TMO_DATA;
          fin_c = 1'b1;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      ST_DLY: begin
        abort_d = aborting_c;
        if (dcnt == DLW'(ACK_DELAY - 1)) fin_c  = 1'b1;
        else                             dcnt_d = dcnt + DLW'(1);
      end
      ST_ACK: begin
        if (!wb_stb) begin
          ack_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase

    // An abandoned bus cycle must never see the ack of its completed access.
    if (fin_c) begin
      if (aborting_c) begin
        state_d = ST_DRAIN;
      end else begin
        state_d = ST_ACK;
        ack_d   = 1'b1;
      end
    end
  end

  assign wb_ack       = ack_r & wb_stb;
  assign wb_dat_o     = dat_o;
  assign wb_ready     = ready_r;
  assign tmo          = tmo_r;
  assign sdram_wr_req = wr_req;
  assign sdram_rd_req = rd_req;
  assign sdram_addr   = {1'b0, req.adr};
  assign sdram_wdata  = req.dat;
  assign sdram_udqm   = dqm[1];
  assign sdram_ldqm   = dqm[0];

endmodule

// File: tb/tb_sdram_wb_bridge.sv
// Directed bench for sdram_wb_bridge: stimulus pushes expected bus responses,
// a monitor pops and checks them on every wb_ack rising edge.
module tb_sdram_wb_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_stb = 1'b0, wb_we = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic [20:0] wb_adr = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_ack, wb_ready, tmo, ctl_rst_n;
  logic        sdram_wr_req, sdram_rd_req;
  logic        sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_wdata;
  logic [15:0] sdram_rdata = '0;
  logic        sdram_udqm, sdram_ldqm;
  logic        sdram_init_done = 1'b0;

  typedef struct {
    logic [15:0] dat;
    logic        chk_dat;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_prev = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sdram_wb_bridge #(.RST_DELAY(3), .ACK_DELAY(1), .TIMEOUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wb_stb          (wb_stb),
    .wb_we           (wb_we),
    .wb_sel          (wb_sel),
    .wb_adr          (wb_adr),
    .wb_dat_i        (wb_dat_i),
    .wb_dat_o        (wb_dat_o),
    .wb_ack          (wb_ack),
    .wb_ready        (wb_ready),
    .tmo             (tmo),
    .ctl_rst_n       (ctl_rst_n),
    .sdram_wr_req    (sdram_wr_req),
    .sdram_rd_req    (sdram_rd_req),
    .sdram_wr_ack    (sdram_wr_ack),
    .sdram_rd_ack    (sdram_rd_ack),
    .sdram_addr      (sdram_addr),
    .sdram_wdata     (sdram_wdata),
    .sdram_rdata     (sdram_rdata),
    .sdram_udqm      (sdram_udqm),
    .sdram_ldqm      (sdram_ldqm),
    .sdram_init_done (sdram_init_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start(input logic we, input logic [1:0] sel, input logic [20:0] adr,
                       input logic [15:0] dat);
    wb_we    = we;
    wb_sel   = sel;
    wb_adr   = adr;
    wb_dat_i = dat;
    wb_stb   = 1'b1;
  endtask

  task automatic wait_ack(input string name, input int max);
    int n = 0;
    while (!wb_ack && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(wb_ack), 32'd1);
  endtask

  // Response monitor, sampling mid-cycle away from both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (wb_ack && !mon_prev) begin
        chk("ack_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          if (mon_e.chk_dat) chk("ack_rdata", 32'(wb_dat_o), 32'(mon_e.dat));
          chk("ack_tmo", 32'(tmo), 32'(mon_e.tmo));
        end
      end
      mon_prev = wb_ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic saw_req, got_ack, held;
    sdram_init_done = 1'b1;
    cyc(2);
    chk("rst_ctl_rst_n", 32'(ctl_rst_n), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd0);
    chk("rst_wb_ack", 32'(wb_ack), 32'd0);
    chk("rst_wb_dat_o", 32'(wb_dat_o), 32'd0);
    chk("rst_addr", 32'(sdram_addr), 32'd0);
    chk("rst_reqs", 32'({sdram_wr_req, sdram_rd_req}), 32'd0);
    chk("rst_dqm", 32'({sdram_udqm, sdram_ldqm}), 32'd0);
    chk("rst_tmo", 32'(tmo), 32'd0);

    rst_n = 1'b1;
    cyc(4);
    chk("ctl_rst_n_after_4", 32'(ctl_rst_n), 32'd0);
    cyc(1);
    chk("ctl_rst_n_after_5", 32'(ctl_rst_n), 32'd1);
    chk("wb_ready_after_5", 32'(wb_ready), 32'd0);
    cyc(1);
    chk("wb_ready_after_6", 32'(wb_ready), 32'd1);
    cyc(2);

    // Read with controller ack six cycles after the request rises.
    sb.push_back('{dat: 16'hA5C3, chk_dat: 1'b1, tmo: 1'b0});
    start(1'b0, 2'b11, 21'h012345, 16'h0000);
    cyc(1);
    chk("rd_req_raised", 32'(sdram_rd_req), 32'd1);
    chk("rd_no_wr_req", 32'(sdram_wr_req), 32'd0);
    chk("rd_addr", 32'(sdram_addr), 32'h012345);
    chk("rd_dqm", 32'({sdram_udqm, sdram_ldqm}), 32'd0);
    cyc(6);
    sdram_rd_ack = 1'b1;
    sdram_rdata  = 16'hA5C3;
    cyc(1);
    sdram_rd_ack = 1'b0;
    sdram_rdata  = 16'h0000;
    chk("rd_req_dropped", 32'(sdram_rd_req), 32'd0);
    chk("rd_ack_not_early", 32'(wb_ack), 32'd0);
    cyc(1);
    chk("rd_ack_latency", 32'(wb_ack), 32'd1);
    wb_stb = 1'b0;
    #1;
    chk("rd_ack_follows_stb", 32'(wb_ack), 32'd0);
    cyc(2);

    // High-byte write with a stray non-matching read ack.
    sb.push_back('{dat: 16'h0000, chk_dat: 1'b0, tmo: 1'b0});
    start(1'b1, 2'b10, 21'h000100, 16'h7F00);
    cyc(1);
    chk("wr_req_raised", 32'(sdram_wr_req), 32'd1);
    chk("wr_no_rd_req", 32'(sdram_rd_req), 32'd0);
    chk("wr_dqm", 32'({sdram_udqm, sdram_ldqm}), 32'b01);
    chk("wr_wdata", 32'(sdram_wdata), 32'h7F00);
    chk("wr_addr", 32'(sdram_addr), 32'h000100);
    sdram_rd_ack = 1'b1;
    cyc(1);
    sdram_rd_ack = 1'b0;
    chk("wr_ignores_rd_ack", 32'(sdram_wr_req), 32'd1);
    cyc(1);
    sdram_wr_ack = 1'b1;
    cyc(1);
    sdram_wr_ack = 1'b0;
    chk("wr_req_dropped", 32'(sdram_wr_req), 32'd0);
    wait_ack("wr_ack_seen", 6);
    cyc(3);
    chk("wr_ack_held", 32'(wb_ack), 32'd1);
    chk("wr_dqm_held", 32'({sdram_udqm, sdram_ldqm}), 32'b01);
    wb_stb = 1'b0;
    #1;
    chk("wr_ack_follows_stb", 32'(wb_ack), 32'd0);
    cyc(2);

    // Write with no byte enables bypasses the controller.
    sb.push_back('{dat: 16'h0000, chk_dat: 1'b0, tmo: 1'b0});
    start(1'b1, 2'b00, 21'h000200, 16'h1234);
    saw_req = 1'b0;
    got_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1);
      if (sdram_wr_req || sdram_rd_req) saw_req = 1'b1;
      if (wb_ack) got_ack = 1'b1;
    end
    chk("sel0_no_req", 32'(saw_req), 32'd0);
    chk("sel0_ack", 32'(got_ack), 32'd1);
    chk("sel0_dqm", 32'({sdram_udqm, sdram_ldqm}), 32'b11);
    wb_stb = 1'b0;
    cyc(2);

    // Read the controller never acknowledges.
    sb.push_back('{dat: 16'hFFFF, chk_dat: 1'b1, tmo: 1'b1});
    start(1'b0, 2'b01, 21'h1FFFFF, 16'h0000);
    cyc(1);
    chk("tmo_addr", 32'(sdram_addr), 32'h1FFFFF);
    chk("tmo_rd_dqm", 32'({sdram_udqm, sdram_ldqm}), 32'd0);
    held = sdram_rd_req;
    for (int i = 1; i < 16; i++) begin
      cyc(1);
      if (!sdram_rd_req) held = 1'b0;
    end
    chk("tmo_req_held_16", 32'(held), 32'd1);
    chk("tmo_not_yet", 32'(tmo), 32'd0);
    cyc(1);
    chk("tmo_req_dropped", 32'(sdram_rd_req), 32'd0);
    chk("tmo_flag", 32'(tmo), 32'd1);
    chk("tmo_ack", 32'(wb_ack), 32'd1);
    chk("tmo_data", 32'(wb_dat_o), 32'hFFFF);
    wb_stb = 1'b0;
    cyc(2);

    // Strobe abandoned two cycles into a read, new read issued right after.
    start(1'b0, 2'b11, 21'h0ABCDE, 16'h0000);
    cyc(1);
    chk("abort_req_raised", 32'(sdram_rd_req), 32'd1);
    cyc(2);
    wb_stb = 1'b0;
    cyc(2);
    chk("abort_req_held", 32'(sdram_rd_req), 32'd1);
    sdram_rd_ack = 1'b1;
    sdram_rdata  = 16'h1111;
    cyc(1);
    sdram_rd_ack = 1'b0;
    sdram_rdata  = 16'h0000;
    chk("abort_req_dropped", 32'(sdram_rd_req), 32'd0);
    sb.push_back('{dat: 16'h2468, chk_dat: 1'b1, tmo: 1'b1});
    start(1'b0, 2'b11, 21'h054321, 16'h0000);
    cyc(1);
    chk("abort_rdata_captured", 32'(wb_dat_o), 32'h1111);
    chk("abort_no_ack", 32'(wb_ack), 32'd0);
    for (int i = 0; i < 6 && !sdram_rd_req; i++) cyc(1);
    chk("next_req_raised", 32'(sdram_rd_req), 32'd1);
    chk("next_addr", 32'(sdram_addr), 32'h054321);
    cyc(1);
    sdram_rd_ack = 1'b1;
    sdram_rdata  = 16'h2468;
    cyc(1);
    sdram_rd_ack = 1'b0;
    sdram_rdata  = 16'h0000;
    wait_ack("next_ack_seen", 6);
    cyc(1);
    wb_stb = 1'b0;
    cyc(3);

    chk("tmo_sticky", 32'(tmo), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
